// File: rtl/mdu_pkg.sv
// Shared encodings, states and helpers for the
// multiply/divide sequencer and its datapath.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHU  = 3'd2;
  localparam logic [2:0] OP_MULHSU = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam int MUL_LAT_DEF = 3;
  localparam int DIV_LAT_DEF = 33;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Extend a 32-bit word to 64 bits, signed or unsigned.
  function automatic logic [63:0] word_ext(
    input logic [31:0] x,
    input logic        sgn
  );
    return {{32{sgn & x[31]}}, x};
  endfunction

endpackage

// File: rtl/mac.sv
// Combinational RV64M multiply/divide datapath.
// Driven from stable operand registers as a multicycle path.
module mac
  import mdu_pkg::*;
(
  input  logic [7:0]  op_oh_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] res_o
);

  logic [127:0] a_x;
  logic [127:0] b_x;
  logic [127:0] prod;
  logic         ovf_s;
  logic [63:0]  b_s;
  logic [63:0]  b_u;
  logic [63:0]  quo_s;
  logic [63:0]  quo_u;
  logic [63:0]  rem_s;
  logic [63:0]  rem_u;

  // One shared 128-bit multiplier; operand extension picks the flavour.
  always_comb begin
    a_x = {64'b0, a_i};
    b_x = {64'b0, b_i};
    if (op_oh_i[OP_MULH] | op_oh_i[OP_MULHSU])
      a_x = {{64{a_i[63]}}, a_i};
    if (op_oh_i[OP_MULH])
      b_x = {{64{b_i[63]}}, b_i};
    prod = a_x * b_x;
  end

  // Dividers; divisors are kept benign for cases the sequencer bypasses.
  always_comb begin
    ovf_s = (a_i == 64'h8000_0000_0000_0000) &&
            (b_i == 64'hFFFF_FFFF_FFFF_FFFF);
    b_s   = ((b_i == 64'd0) || ovf_s) ? 64'd1 : b_i;
    b_u   = (b_i == 64'd0) ? 64'd1 : b_i;
    quo_s = $signed(a_i) / $signed(b_s);
    rem_s = $signed(a_i) % $signed(b_s);
    quo_u = a_i / b_u;
    rem_u = a_i % b_u;
  end

  // Result select by one-hot op.
  always_comb begin
    res_o = '0;
    unique case (1'b1)
      op_oh_i[OP_MUL]:    res_o = prod[63:0];
      op_oh_i[OP_MULH],
      op_oh_i[OP_MULHU],
      op_oh_i[OP_MULHSU]: res_o = prod[127:64];
      op_oh_i[OP_DIV]:    res_o = quo_s;
      op_oh_i[OP_DIVU]:   res_o = quo_u;
      op_oh_i[OP_REM]:    res_o = rem_s;
      op_oh_i[OP_REMU]:   res_o = rem_u;
      default:            res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle sequencer around the mac datapath:
// handshake, special cases, word handling, flush.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       op_oh_q;
  logic             word_q;
  logic [63:0]      a_q;
  logic [63:0]      b_q;
  logic             out_valid_q;
  logic [63:0]      out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             busy_q;

  logic        is_div_d;
  logic        word_d;
  logic        uns_d;
  logic [63:0] a_d;
  logic [63:0] b_d;
  logic        div0_d;
  logic        ovf_d;
  logic [63:0] fast_raw_d;
  logic [63:0] fast_d;
  logic [63:0] mac_res;
  logic [63:0] cap_d;

  assign in_ready   = (state_q == IDLE) & ~flush;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = busy_q;

  // Operand pre-processing and divide special-case resolution.
  always_comb begin
    is_div_d = in_op[2];
    word_d   = in_word & (is_div_d | (in_op == OP_MUL));
    uns_d    = is_div_d & in_op[0];
    a_d      = word_d ? word_ext(in_src1[31:0], ~uns_d) : in_src1;
    b_d      = word_d ? word_ext(in_src2[31:0], ~uns_d) : in_src2;
    div0_d   = is_div_d & (b_d == 64'd0);
    ovf_d    = is_div_d & ~in_op[0] &
               (word_d ?
                 ((in_src1[31:0] == 32'h8000_0000) &&
                  (in_src2[31:0] == 32'hFFFF_FFFF)) :
                 ((in_src1 == 64'h8000_0000_0000_0000) &&
                  (in_src2 == 64'hFFFF_FFFF_FFFF_FFFF)));
    if (div0_d)
      fast_raw_d = in_op[1] ? a_d : 64'hFFFF_FFFF_FFFF_FFFF;
    else
      fast_raw_d = in_op[1] ? 64'd0 : a_d;
    fast_d = word_d ? word_ext(fast_raw_d[31:0], 1'b1) : fast_raw_d;
    cap_d  = word_q ? word_ext(mac_res[31:0], 1'b1) : mac_res;
  end

  mac u_mac (
    .op_oh_i (op_oh_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .res_o   (mac_res)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_oh_q      <= 8'd1;
      word_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      busy_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_oh_q   <= 8'd1 << in_op;
            word_q    <= word_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_tag_q <= in_tag;
            busy_q    <= 1'b1;
            if (div0_d | ovf_d) begin
              out_result_q <= fast_d;
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end else begin
              cnt_q   <= is_div_d ? DIV_CNT : MUL_CNT;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            out_result_q <= cap_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed ops push
// expected results; a monitor pops on each handshake.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t q[$];

  logic        prev_v;
  int          rise;
  logic [63:0] held_res;
  logic [4:0]  held_tag;

  mdu_ctrl #(.MUL_LAT(3), .DIV_LAT(33), .TAG_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string nm);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: stability while held, and scoreboard pop on handshake.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        rise     = cyc;
        held_res = out_result;
        held_tag = out_tag;
      end else if (out_valid && prev_v) begin
        chk("hold_result", out_result, held_res);
        chk("hold_tag", 64'(out_tag), 64'(held_tag));
      end
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          fail_msg("unexpected_out_valid");
        end else begin
          e = q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("out_cycle", 64'(rise), 64'(e.cyc));
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input logic [2:0] op, input logic w,
                       input logic [63:0] s1, input logic [63:0] s2,
                       input logic [4:0] tg, input logic [63:0] exp,
                       input int lat, input bit push, output int acc);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    acc = cyc;
    if (!in_ready) begin
      fail_msg("accept_timeout");
      return;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_word  = w;
    in_src1  = s1;
    in_src2  = s2;
    in_tag   = tg;
    if (push) begin
      e.res = exp;
      e.tag = tg;
      e.cyc = cyc + lat;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      fail_msg("drain_timeout");
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, t0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_word   = 1'b0;
    in_src1   = '0;
    in_src2   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    prev_v    = 1'b0;
    rise      = 0;
    held_res  = '0;
    held_tag  = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;

    // MUL latency and return to idle
    issue(OP_MUL, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
          64'hFFFF_FFFF_FFFF_FFEB, 3, 1, t0);
    chk("mul_valid_T1", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    chk("mul_valid_T2", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    chk("mul_valid_T3", 64'(out_valid), 64'd1);
    @(posedge clock); #1;
    chk("mul_busy_T4", 64'(busy), 64'd0);
    chk("mul_in_ready_T4", 64'(in_ready), 64'd1);
    drain();

    // Throughput: normal path LAT+1, fast path 2
    issue(OP_MUL, 0, 64'd6, 64'd7, 5'd1, 64'd42, 3, 1, a0);
    issue(OP_MUL, 0, 64'd3, 64'd5, 5'd2, 64'd15, 3, 1, a1);
    chk("mul_throughput", 64'(a1 - a0), 64'd4);
    issue(OP_DIV, 0, 64'd100, 64'd0, 5'd3,
          64'hFFFF_FFFF_FFFF_FFFF, 1, 1, a0);
    issue(OP_REMUW_or(), 1, 64'h1_8000_0000, 64'd0, 5'd4,
          64'hFFFF_FFFF_8000_0000, 1, 1, a1);
    chk("fast_throughput", 64'(a1 - a0), 64'd2);
    drain();

    // Overflow fast paths
    issue(OP_DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd6,
          64'hFFFF_FFFF_8000_0000, 1, 1, a0);
    issue(OP_REM, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          5'd7, 64'd0, 1, 1, a0);
    issue(OP_DIV, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          5'd8, 64'h8000_0000_0000_0000, 1, 1, a0);
    issue(OP_DIVU, 1, 64'h1234_0000_0000_0005, 64'hFFFF_FFFF_0000_0000,
          5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, a0);
    drain();

    // Normal path mix, including word forms
    issue(OP_MUL, 1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF,
          5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 3, 1, a0);
    issue(OP_MULH, 0, 64'hC000_0000_0000_0000, 64'd8, 5'd11,
          64'hFFFF_FFFF_FFFF_FFFE, 3, 1, a0);
    issue(OP_MULH, 1, 64'hC000_0000_0000_0000, 64'd8, 5'd12,
          64'hFFFF_FFFF_FFFF_FFFE, 3, 1, a0);
    issue(OP_MULHSU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd13,
          64'hFFFF_FFFF_FFFF_FFFF, 3, 1, a0);
    issue(OP_MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd14,
          64'd1, 3, 1, a0);
    issue(OP_DIVU, 1, 64'hABCD_0000_FFFF_FFFF, 64'd2, 5'd15,
          64'h0000_0000_7FFF_FFFF, 33, 1, a0);
    issue(OP_DIVU, 1, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'd16,
          64'hFFFF_FFFF_FFFF_FFFE, 33, 1, a0);
    issue(OP_REM, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd17,
          64'hFFFF_FFFF_FFFF_FFFF, 33, 1, a0);
    issue(OP_DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd18,
          64'hFFFF_FFFF_FFFF_FFFD, 33, 1, a0);
    issue(OP_REMU, 0, 64'd100, 64'd7, 5'd19, 64'd2, 33, 1, a0);
    drain();

    // DIVU with consumer stalled for 10 cycles
    out_ready = 1'b0;
    issue(OP_DIVU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd20,
          64'h0FFF_FFFF_FFFF_FFFF, 33, 1, t0);
    repeat (32) @(posedge clock);
    #1;
    chk("divu_valid_T33", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Flush during a DIV, then immediate MULHU
    issue(OP_DIV, 0, 64'd1000, 64'd3, 5'd21, 64'd0, 33, 0, t0);
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    #1;
    chk("flush_in_ready_T11", 64'(in_ready), 64'd1);
    issue(OP_MULHU, 0, 64'h8000_0000_0000_0000, 64'd4, 5'd3,
          64'd2, 3, 1, a0);
    chk("post_flush_accept", 64'(a0), 64'(t0 + 11));
    drain();

    // Flush beats same-cycle in_valid
    in_valid = 1'b1;
    in_op    = OP_MUL;
    in_word  = 1'b0;
    in_src1  = 64'd2;
    in_src2  = 64'd2;
    in_tag   = 5'd7;
    flush    = 1'b1;
    #1;
    chk("flush_valid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_valid_no_accept", 64'(busy), 64'd0);
    repeat (5) @(posedge clock);
    #1;

    // Asynchronous reset in CALC
    issue(OP_DIVU, 0, 64'd1000, 64'd3, 5'd22, 64'd0, 33, 0, t0);
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    issue(OP_MUL, 0, 64'd9, 64'd9, 5'd23, 64'd81, 3, 1, a0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic [2:0] OP_REMUW_or();
    return OP_REMU;
  endfunction

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle sequencer that wraps the combinational `mac` multiply/divide datapath for the execute stage. It accepts one RV64M operation at a time over a valid/ready handshake and holds the operands stable for a fixed multicycle-path budget. It resolves divide-by-zero and signed-overflow cases and the *W word variants without using the datapath, then presents a registered result with a tag until the consumer takes it. Flush support lets the pipeline kill an in-flight operation.

## Interface
- MUL_LAT, 3: cycles from accept to out_valid for MUL/MULH/MULHU/MULHSU; must be >= 2.
- DIV_LAT, 33: cycles from accept to out_valid for DIV/DIVU/REM/REMU; must be >= 2.
- TAG_W, 5: width of the pass-through tag.

- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high.
- flush  in  1  kills any in-flight or pending op.
- in_valid  in  1  request valid.
- in_ready  out  1  equals state==IDLE & ~flush.
- in_op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 MULHSU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_word  in  1  *W variant. Legal only with MUL/DIV/DIVU/REM/REMU; ignored for MULH*.
- in_src1, in_src2  in  64  operands.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  64  registered result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, DONE. Reset puts the block in IDLE with out_valid=0, out_result=0, out_tag=0, busy=0. in_ready reads 1 once out of reset with flush low.
- Accept happens when in_valid & in_ready. On accept:
  - Register the op one-hot, the tag and the pre-processed operands.
  - Word signed ops (MULW, DIVW, REMW): sign-extend src[31:0].
  - Word unsigned ops (DIVUW, REMUW): zero-extend src[31:0].
- Fast path, from IDLE directly to DONE without visiting CALC:
  - Divisor==0: DIV/DIVU → all ones; REM/REMU → extended src1.
  - Signed overflow (most-negative ÷ -1, at 64 or 32 bits per in_word): DIV → src1; REM → 0.
- Normal path: IDLE→CALC, counter loaded with LAT-2. `mac` is driven only from the registered operands and one-hot, so its inputs are constant throughout CALC. When the counter reaches 0, capture the `mac` output into out_result and go to DONE.
- Word results: out_result = sign-extend(result[31:0]). This applies to every word op, including DIVUW/REMUW and fast-path results.
- DONE: out_valid=1. Hold out_result and out_tag stable until out_ready, then go to IDLE. No accept is allowed in DONE.
- flush: from any state, go to IDLE at the next edge with out_valid=0 and the result discarded. Flush wins over a same-cycle in_valid (in_ready=0, no accept) and over a same-cycle out_ready.
- Reset mid-operation: immediately back to IDLE with all outputs at reset values.

## Timing
- Accept edge at end of cycle T. Normal path: out_valid rises in cycle T+LAT, where LAT = MUL_LAT or DIV_LAT by op class. Fast path: out_valid in cycle T+1.
- CALC lasts LAT-1 cycles. Counter width is clog2(DIV_LAT).
- Throughput with out_ready held high: one op per LAT+1 cycles (fast path: one per 2 cycles).
- out_valid, out_result, out_tag and busy are registered. in_ready is combinational from state and flush only, with no path from in_valid.

## Structure
- Package `mdu_pkg` holds:
  - op encoding localparams;
  - state enum;
  - default MUL_LAT/DIV_LAT;
  - a function word_ext(x, signed).
- One sub-module instance: the existing `mac` datapath, fed from the operand registers. Special-case detection and output capture stay in `mdu_ctrl`.
- Timing constraints declare `mac` paths as multicycle = MUL_LAT-1 / DIV_LAT-1 from the operand registers.

## Test plan
- MUL, src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD), tag 5, out_ready=1, accept T → out_valid exactly at T+3, result 0xFFFF_FFFF_FFFF_FFEB, tag 5; back to IDLE at T+4.
- DIV, src1=100, src2=0 → out_valid at T+1 with 0xFFFF_FFFF_FFFF_FFFF. REMUW, src1=0x1_8000_0000, src2=0 → 0xFFFF_FFFF_8000_0000.
- DIVW, src1=0x8000_0000, src2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 at T+1. DIV, 64-bit, src1=0x8000_0000_0000_0000, src2=-1 → REM variant gives 0.
- DIVU, src1=0xFFFF_FFFF_FFFF_FFFF, src2=16 → out_valid at T+33 with 0x0FFF_FFFF_FFFF_FFFF. With out_ready=0 for 10 cycles, the result is held stable and in_ready stays 0.
- Flush at T+10 of a DIV → out_valid never rises. in_ready is 1 at T+11 and a new MULHU (2^63 × 4) accepted at T+11 returns 2 at T+14. A flush in the same cycle as in_valid is not accepted.
- Assert reset during CALC → all outputs reach reset values asynchronously. MULH with in_word=1 behaves identically to in_word=0.
